// File: rtl/elevator_request_latch.sv
// Parametrised elevator request register: latches hall/car calls on press edges,
// clears calls served at the current floor and summarises requests around the car.
module elevator_request_latch #(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic [1:0]            cur_dir,
  input  logic                  door_open,
  input  logic                  flush,
  input  logic [NUM_FLOORS-1:0] hall_up_btn,
  input  logic [NUM_FLOORS-1:0] hall_dn_btn,
  input  logic [NUM_FLOORS-1:0] car_btn,
  output logic [NUM_FLOORS-1:0] hall_up_req,
  output logic [NUM_FLOORS-1:0] hall_dn_req,
  output logic [NUM_FLOORS-1:0] car_req,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  req_here,
  output logic                  served
);

  localparam logic [31:0] NF = 32'(NUM_FLOORS);
  // No hall up call exists at the top floor, no hall down call at the bottom floor.
  localparam logic [NUM_FLOORS-1:0] LEGAL_UP = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] LEGAL_DN = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  logic [NUM_FLOORS-1:0] hall_up_btn_q, hall_dn_btn_q, car_btn_q;
  logic [NUM_FLOORS-1:0] hall_up_req_q, hall_dn_req_q, car_req_q;
  logic [NUM_FLOORS-1:0] hall_up_req_d, hall_dn_req_d, car_req_d;
  logic                  served_q, served_d;

  logic [31:0]           cur_ext_s;
  logic                  in_range_s, dir_up_s, dir_dn_s, dir_idle_s;
  logic [NUM_FLOORS-1:0] floor_hot_s, clr_up_s, clr_dn_s, clr_car_s;
  logic [NUM_FLOORS-1:0] rise_up_s, rise_dn_s, rise_car_s, any_req_s;

  // Request next-state: flush beats service clear, which beats a new press.
  always_comb begin
    cur_ext_s  = 32'(cur_floor);
    in_range_s = (cur_ext_s < NF);
    dir_up_s   = (cur_dir == 2'b01);
    dir_dn_s   = (cur_dir == 2'b10);
    dir_idle_s = !dir_up_s && !dir_dn_s;
    floor_hot_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_hot_s[i] = in_range_s && (cur_ext_s == 32'(i));
    end
    if (door_open) begin
      clr_car_s = floor_hot_s;
      clr_up_s  = (dir_up_s || dir_idle_s) ? floor_hot_s : '0;
      clr_dn_s  = (dir_dn_s || dir_idle_s) ? floor_hot_s : '0;
    end else begin
      clr_car_s = '0;
      clr_up_s  = '0;
      clr_dn_s  = '0;
    end
    rise_up_s  = hall_up_btn & ~hall_up_btn_q;
    rise_dn_s  = hall_dn_btn & ~hall_dn_btn_q;
    rise_car_s = car_btn & ~car_btn_q;
    if (flush) begin
      hall_up_req_d = '0;
      hall_dn_req_d = '0;
      car_req_d     = '0;
      served_d      = 1'b0;
    end else begin
      hall_up_req_d = (hall_up_req_q | rise_up_s) & ~clr_up_s & LEGAL_UP;
      hall_dn_req_d = (hall_dn_req_q | rise_dn_s) & ~clr_dn_s & LEGAL_DN;
      car_req_d     = (car_req_q | rise_car_s) & ~clr_car_s;
      served_d      = |((hall_up_req_q & clr_up_s) | (hall_dn_req_q & clr_dn_s) |
                        (car_req_q & clr_car_s));
    end
  end

  // Summaries relative to the car; an out-of-range floor sees every floor below it.
  always_comb begin
    any_req_s = hall_up_req_q | hall_dn_req_q | car_req_q;
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (32'(i) > cur_ext_s) begin
        req_above = req_above | any_req_s[i];
      end else if (32'(i) < cur_ext_s) begin
        req_below = req_below | any_req_s[i];
      end else begin
        req_here = req_here | any_req_s[i];
      end
    end
  end

  // State registers; during reset the edge detectors track the button levels.
  always_ff @(posedge clk) begin
    hall_up_btn_q <= hall_up_btn;
    hall_dn_btn_q <= hall_dn_btn;
    car_btn_q     <= car_btn;
    if (reset) begin
      hall_up_req_q <= '0;
      hall_dn_req_q <= '0;
      car_req_q     <= '0;
      served_q      <= 1'b0;
    end else begin
      hall_up_req_q <= hall_up_req_d;
      hall_dn_req_q <= hall_dn_req_d;
      car_req_q     <= car_req_d;
      served_q      <= served_d;
    end
  end

  assign hall_up_req = hall_up_req_q;
  assign hall_dn_req = hall_dn_req_q;
  assign car_req     = car_req_q;
  assign served      = served_q;

endmodule

// File: tb/tb_elevator_request_latch.sv
// Scoreboard bench for elevator_request_latch: a 7-floor and a 12-floor instance.
module tb_elevator_request_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cf;
  logic [1:0]  dir;
  logic        door, flush;
  logic [6:0]  hu, hd, cb;
  logic [6:0]  hu_r, hd_r, car_r;
  logic        above, below, here, served;

  logic [3:0]  cf12;
  logic        door12;
  logic [11:0] hu12, hd12, cb12;
  logic [11:0] hu12_r, hd12_r, car12_r;
  logic        above12, below12, here12, served12;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_request_latch #(.NUM_FLOORS(7), .FLOOR_W(3)) dut7 (
    .clk(clk), .reset(reset), .cur_floor(cf), .cur_dir(dir), .door_open(door),
    .flush(flush), .hall_up_btn(hu), .hall_dn_btn(hd), .car_btn(cb),
    .hall_up_req(hu_r), .hall_dn_req(hd_r), .car_req(car_r),
    .req_above(above), .req_below(below), .req_here(here), .served(served)
  );

  elevator_request_latch #(.NUM_FLOORS(12), .FLOOR_W(4)) dut12 (
    .clk(clk), .reset(reset), .cur_floor(cf12), .cur_dir(dir), .door_open(door12),
    .flush(flush), .hall_up_btn(hu12), .hall_dn_btn(hd12), .car_btn(cb12),
    .hall_up_req(hu12_r), .hall_dn_req(hd12_r), .car_req(car12_r),
    .req_above(above12), .req_below(below12), .req_here(here12), .served(served12)
  );

  localparam int HU = 0, HD = 1, CAR = 2, ABV = 3, BLW = 4, HERE = 5, SRV = 6;
  localparam int HU12 = 10, CAR12 = 12, ABV12 = 13, BLW12 = 14, HERE12 = 15, SRV12 = 16;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      HU:      return 32'(hu_r);
      HD:      return 32'(hd_r);
      CAR:     return 32'(car_r);
      ABV:     return 32'(above);
      BLW:     return 32'(below);
      HERE:    return 32'(here);
      SRV:     return 32'(served);
      HU12:    return 32'(hu12_r);
      CAR12:   return 32'(car12_r);
      ABV12:   return 32'(above12);
      BLW12:   return 32'(below12);
      HERE12:  return 32'(here12);
      SRV12:   return 32'(served12);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_expect(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cf = 3'd0; dir = 2'b00; door = 1'b0; flush = 1'b0;
    hu = 7'd0; hd = 7'd0; cb = 7'b0010000;
    cf12 = 4'd13; door12 = 1'b0; hu12 = 12'd0; hd12 = 12'd0; cb12 = 12'd0;
    tick(); tick();
    reset = 1'b0;
    sb_expect("rst_hu", HU, 32'd0);
    sb_expect("rst_hd", HD, 32'd0);
    sb_expect("rst_car", CAR, 32'd0);
    sb_expect("rst_served", SRV, 32'd0);
    sb_expect("rst_car12", CAR12, 32'd0);
    tick(); sb_drain();

    // Button held through reset must not latch.
    for (int i = 0; i < 5; i++) tick();
    sb_expect("held_btn", CAR, 32'd0);
    sb_drain();
    cb = 7'd0; tick();
    cb = 7'b0010000;
    #1;
    sb_expect("press_pre_edge", CAR, 32'd0);
    sb_drain();
    sb_expect("press_post_edge", CAR, 32'h10);
    tick(); sb_drain();
    cb = 7'd0;

    // Floor 2, travelling up: the down call stays.
    hu = 7'b0000100; hd = 7'b0000100; cb = 7'b0000100; tick();
    hu = 7'd0; hd = 7'd0; cb = 7'd0;
    sb_expect("set2_hu", HU, 32'h04);
    sb_expect("set2_hd", HD, 32'h04);
    sb_expect("set2_car", CAR, 32'h14);
    tick(); sb_drain();
    cf = 3'd2; dir = 2'b01; door = 1'b1;
    sb_expect("up_hu", HU, 32'h00);
    sb_expect("up_hd", HD, 32'h04);
    sb_expect("up_car", CAR, 32'h10);
    sb_expect("up_served", SRV, 32'd1);
    sb_expect("up_here", HERE, 32'd1);
    sb_expect("up_above", ABV, 32'd1);
    sb_expect("up_below", BLW, 32'd0);
    tick(); sb_drain();
    door = 1'b0;
    sb_expect("up_served_off", SRV, 32'd0);
    sb_expect("up_hd_keep", HD, 32'h04);
    tick(); sb_drain();

    // Floor 2, idle: everything clears and a press during service is absorbed.
    hu = 7'b0000100; cb = 7'b0000100; tick();
    hu = 7'd0; cb = 7'd0;
    sb_expect("reset2_hu", HU, 32'h04);
    sb_expect("reset2_car", CAR, 32'h14);
    tick(); sb_drain();
    dir = 2'b00; door = 1'b1;
    sb_expect("idle_hu", HU, 32'h00);
    sb_expect("idle_hd", HD, 32'h00);
    sb_expect("idle_car", CAR, 32'h10);
    sb_expect("idle_served", SRV, 32'd1);
    tick(); sb_drain();
    hd = 7'b0000100;
    sb_expect("absorb_hd", HD, 32'h00);
    sb_expect("absorb_served", SRV, 32'd0);
    tick(); sb_drain();
    hd = 7'd0;
    sb_expect("absorb_hd2", HD, 32'h00);
    sb_expect("absorb_served2", SRV, 32'd0);
    tick(); sb_drain();
    door = 1'b0; tick();

    // Illegal hall bits, then a legal top-floor down call.
    hu = 7'b1000000; hd = 7'b0000001; tick();
    hu = 7'd0; hd = 7'd0;
    sb_expect("illegal_hu", HU, 32'h00);
    sb_expect("illegal_hd", HD, 32'h00);
    tick(); sb_drain();
    hd = 7'b1000000; tick();
    hd = 7'd0; cf = 3'd3;
    sb_expect("top_dn_hd", HD, 32'h40);
    sb_expect("top_dn_above", ABV, 32'd1);
    sb_expect("top_dn_below", BLW, 32'd0);
    sb_expect("top_dn_here", HERE, 32'd0);
    tick(); sb_drain();

    // Floor 5 travelling down: up call survives.
    hu = 7'b0100000; hd = 7'b0100000; tick();
    hu = 7'd0; hd = 7'd0; tick();
    cf = 3'd5; dir = 2'b10; door = 1'b1;
    sb_expect("dn_hu", HU, 32'h20);
    sb_expect("dn_hd", HD, 32'h40);
    sb_expect("dn_served", SRV, 32'd1);
    sb_expect("dn_here", HERE, 32'd1);
    sb_expect("dn_above", ABV, 32'd1);
    sb_expect("dn_below", BLW, 32'd1);
    tick(); sb_drain();
    door = 1'b0; dir = 2'b00; tick();

    // Flush wins over a simultaneous press and never reports service.
    cb = 7'b1010010; tick();
    cb = 7'd0;
    sb_expect("preflush_car", CAR, 32'h52);
    tick(); sb_drain();
    flush = 1'b1; cb = 7'b0000001;
    sb_expect("flush_hu", HU, 32'h00);
    sb_expect("flush_hd", HD, 32'h00);
    sb_expect("flush_car", CAR, 32'h00);
    sb_expect("flush_served", SRV, 32'd0);
    tick(); sb_drain();
    flush = 1'b0; cb = 7'd0;
    sb_expect("postflush_car", CAR, 32'h00);
    tick(); sb_drain();

    // 12-floor instance parked at an out-of-range floor with the door open.
    hu12 = 12'h008; cb12 = 12'h020; tick();
    hu12 = 12'd0; cb12 = 12'd0; door12 = 1'b1;
    tick(); tick();
    sb_expect("oor_car", CAR12, 32'h020);
    sb_expect("oor_hu", HU12, 32'h008);
    sb_expect("oor_served", SRV12, 32'd0);
    sb_expect("oor_here", HERE12, 32'd0);
    sb_expect("oor_above", ABV12, 32'd0);
    sb_expect("oor_below", BLW12, 32'd1);
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
